// File: rtl/wb_fifo_slave_pkg.sv
// Shared constants for wb_fifo_slave: register word offsets, CTRL/STATUS bit positions
// and the default ID value.
package wb_fifo_slave_pkg;

  localparam logic [2:0] REG_ID       = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_TX_DATA  = 3'd3;
  localparam logic [2:0] REG_RX_DATA  = 3'd4;
  localparam logic [2:0] REG_TX_LEVEL = 3'd5;
  localparam logic [2:0] REG_RX_LEVEL = 3'd6;

  localparam int unsigned CTRL_TX_FLUSH  = 0;
  localparam int unsigned CTRL_RX_FLUSH  = 1;
  localparam int unsigned CTRL_RX_IRQ_EN = 2;

  localparam int unsigned ST_TX_FULL      = 0;
  localparam int unsigned ST_TX_EMPTY     = 1;
  localparam int unsigned ST_RX_FULL      = 2;
  localparam int unsigned ST_RX_EMPTY     = 3;
  localparam int unsigned ST_TX_OVERFLOW  = 4;
  localparam int unsigned ST_RX_UNDERFLOW = 5;
  localparam int unsigned ST_BAD_SEL      = 6;

  localparam logic [15:0] ID_DEFAULT = 16'hF1F0;

endpackage

// File: rtl/wb_sync_fifo.sv
// Single-clock FIFO with explicit occupancy count; flush takes priority over push/pop.
// Push into a full FIFO and pop from an empty one are ignored.
module wb_sync_fifo #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [DWIDTH-1:0] pop_data,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [AWIDTH:0]   count
);

  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] FULL_COUNT = (AWIDTH + 1)'(DEPTH);

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full     = (count_q == FULL_COUNT);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only words below count are ever observed.
  always_ff @(posedge clk) begin
    if (push_ok && !flush && !rst) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/wb_fifo_slave.sv
// Wishbone slave with ID/CTRL/STATUS registers and TX/RX 16-bit stream FIFOs.
// Define WB_FIFO_SLAVE_IRQ_EN to add the registered irq output and CTRL.rx_irq_en.
module wb_fifo_slave
  import wb_fifo_slave_pkg::*;
#(
  parameter int unsigned FIFO_AWIDTH = 4,
  parameter logic [15:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [10:0] wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  output logic        wb_ack_o,
  output logic [15:0] tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  input  logic [15:0] rx_tdata,
  input  logic        rx_tvalid,
  output logic        rx_tready
`ifdef WB_FIFO_SLAVE_IRQ_EN
  ,
  output logic        irq
`endif
);

  logic        ack_q, ack_d;
  logic [15:0] dat_q, dat_d;
  logic [2:0]  sticky_q, sticky_d;  // {bad_sel, rx_underflow, tx_overflow}
  logic [2:0]  sticky_set, sticky_clr;
  logic        irq_en;

  logic        access, decoded, wr_hit, rd_hit, full_sel;
  logic [2:0]  word;
  logic        tx_push, tx_flush, rx_pop, rx_flush;
  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic [FIFO_AWIDTH:0] tx_count, rx_count;
  logic [15:0] rx_head, rd_data;
  logic        unused_adr;

  assign unused_adr = wb_adr_i[0];

  // A held strobe is ignored during the ack cycle so it is not re-acked.
  assign access   = wb_cyc_i & wb_stb_i & ~ack_q;
  assign decoded  = (wb_adr_i[10:4] == 7'd0);
  assign word     = wb_adr_i[3:1];
  assign wr_hit   = access & wb_we_i & decoded;
  assign rd_hit   = access & ~wb_we_i & decoded;
  assign full_sel = (wb_sel_i == 2'b11);

  assign tx_push  = wr_hit & (word == REG_TX_DATA) & full_sel;
  assign tx_flush = wr_hit & (word == REG_CTRL) & wb_sel_i[0] & wb_dat_i[CTRL_TX_FLUSH];
  assign rx_flush = wr_hit & (word == REG_CTRL) & wb_sel_i[0] & wb_dat_i[CTRL_RX_FLUSH];
  assign rx_pop   = rd_hit & (word == REG_RX_DATA);

  wb_sync_fifo #(
    .DWIDTH (16),
    .AWIDTH (FIFO_AWIDTH)
  ) u_tx_fifo (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .push      (tx_push),
    .push_data (wb_dat_i),
    .pop       (tx_tready),
    .pop_data  (tx_tdata),
    .flush     (tx_flush),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  wb_sync_fifo #(
    .DWIDTH (16),
    .AWIDTH (FIFO_AWIDTH)
  ) u_rx_fifo (
    .clk       (wb_clk),
    .rst       (wb_rst),
    .push      (rx_tvalid),
    .push_data (rx_tdata),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .flush     (rx_flush),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign tx_tvalid = ~tx_empty;
  assign rx_tready = ~rx_full;

  assign sticky_set = {wr_hit & (word == REG_TX_DATA) & ~full_sel,
                       rx_pop & rx_empty,
                       tx_push & tx_full};
  assign sticky_clr = (wr_hit && word == REG_STATUS && wb_sel_i[0]) ?
                      wb_dat_i[ST_BAD_SEL:ST_TX_OVERFLOW] : 3'b000;
  assign sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;

  always_comb begin
    rd_data = '0;
    if (decoded) begin
      case (word)
        REG_ID:       rd_data = ID_VALUE;
        REG_CTRL:     rd_data[CTRL_RX_IRQ_EN] = irq_en;
        REG_STATUS: begin
          rd_data[ST_TX_FULL]                      = tx_full;
          rd_data[ST_TX_EMPTY]                     = tx_empty;
          rd_data[ST_RX_FULL]                      = rx_full;
          rd_data[ST_RX_EMPTY]                     = rx_empty;
          rd_data[ST_BAD_SEL:ST_TX_OVERFLOW]       = sticky_q;
        end
        REG_RX_DATA:  rd_data = rx_empty ? 16'h0000 : rx_head;
        REG_TX_LEVEL: rd_data = 16'(tx_count);
        REG_RX_LEVEL: rd_data = 16'(rx_count);
        default:      rd_data = '0;
      endcase
    end
  end

  assign ack_d = access;
  assign dat_d = (access && !wb_we_i) ? rd_data : 16'h0000;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      sticky_q <= '0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      sticky_q <= sticky_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;

`ifdef WB_FIFO_SLAVE_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_q, irq_d;

  assign irq_en_d = (wr_hit && word == REG_CTRL && wb_sel_i[0]) ?
                    wb_dat_i[CTRL_RX_IRQ_EN] : irq_en_q;
  assign irq_d    = (irq_en_q & ~rx_empty) | (|sticky_q);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en = irq_en_q;
  assign irq    = irq_q;
`else
  assign irq_en = 1'b0;
`endif

endmodule

// File: doc/wb_fifo_slave.md
Name: wb_fifo_slave

Overview:
- Wishbone slave that sits directly downstream of the GPMC-to-Wishbone master.
- Exposes a small register map plus two 16-bit FIFOs:
  - TX: host to fabric, drained on a valid/ready stream.
  - RX: fabric to host, filled from a valid/ready stream.
- Gives the processor a buffered streaming channel into the FPGA fabric; all logic runs in the wb_clk domain.

Parameters:
- FIFO_AWIDTH, 4: log2 of each FIFO depth (16 entries); legal range 2..7.
- ID_VALUE, 16'hF1F0: constant returned by the ID register.

Ports:
- wb_clk  in  1  system clock, all logic on rising edge.
- wb_rst  in  1  synchronous, active-high reset.
- wb_adr_i  in  11  byte address; word select is wb_adr_i[3:1], bits [10:4] must be 0 to decode.
- wb_dat_i  in  16  write data.
- wb_dat_o  out  16  read data, valid while wb_ack_o is high.
- wb_sel_i  in  2  byte-lane enables; [1] = D[15:8].
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write.
- wb_ack_o  out  1  single-cycle acknowledge.
- tx_tdata  out  16  TX FIFO head.
- tx_tvalid  out  1  TX FIFO not empty.
- tx_tready  in  1  fabric pop.
- rx_tdata  in  16  fabric data into RX FIFO.
- rx_tvalid  in  1  fabric push request.
- rx_tready  out  1  RX FIFO not full.

Behaviour:
Reset:
- wb_ack_o=0, wb_dat_o=0, CTRL=0, sticky bits=0, both FIFOs empty.
- Hence tx_tvalid=0 and rx_tready=1.
- Reset asserted mid-transaction aborts it; no ack is issued.

Bus handshake:
- Access = cyc & stb & ~wb_ack_o.
- wb_ack_o is registered high the cycle after an access is sampled, for exactly one cycle.
- wb_dat_o is registered in the same edge; read latency is 1 cycle.
- A strobe held across the ack cycle is not re-acked; a new access needs stb sampled again after ack falls.
- Every decoded or undecoded access is acked; the bus never hangs.
- Undecoded reads return 0; undecoded writes are ignored.

Register map (word offset = adr[3:1]):
- 0 ID (RO): ID_VALUE.
- 1 CTRL (RW, per byte lane):
  - bit0 tx_flush, bit1 rx_flush: write-1 self-clearing, always read 0.
  - bit2 rx_irq_en.
  - other bits read 0.
- 2 STATUS: bits 3:0 are RO, bits 6:4 are sticky and write-1-to-clear (lane 0 only).
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty.
  - bit4 tx_overflow, bit5 rx_underflow, bit6 bad_sel.
- 3 TX_DATA (WO): push wb_dat_i.
  - Requires sel==2'b11; otherwise no push and bad_sel is set.
  - Push while full: data dropped, tx_overflow set.
- 4 RX_DATA (RO): pop at the access cycle; head word returned with ack.
  - Pop while empty: returns 0, rx_underflow set.
- 5 TX_LEVEL (RO): zero-extended TX count, FIFO_AWIDTH+1 bits.
- 6 RX_LEVEL (RO): zero-extended RX count.
- 7: reserved, reads 0.

FIFO rules:
- Full/empty are evaluated from state at the start of the cycle.
- A host push into a full TX FIFO is dropped even if tx_tready pops in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Flush wins over any same-cycle push or pop: count becomes 0 and pointers reset.
- The flushed FIFO's valid/ready outputs update the next cycle.
- Pointers wrap modulo 2^FIFO_AWIDTH; count saturates at 2^FIFO_AWIDTH (full) by construction.
- tx_tdata shows the head combinationally from FIFO storage.
- A sticky set and a W1C clear in the same cycle: set wins.

Optional Feature:
- Macro WB_FIFO_SLAVE_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit, registered, reset 0).
  - irq = (rx_irq_en & ~rx_empty) | tx_overflow | rx_underflow | bad_sel.
  - Level-sensitive; deasserts one cycle after the cause clears.
- Undefined:
  - No irq port.
  - CTRL bit2 is unimplemented and reads 0.

Decomposition:
- Package wb_fifo_slave_pkg holds:
  - register word offsets (REG_ID..REG_RX_LEVEL);
  - CTRL and STATUS bit positions;
  - ID default.
- Sub-module wb_sync_fifo (parameter DWIDTH, AWIDTH) is instantiated twice, once for TX and once for RX.
  - Ports: push, push_data, pop, pop_data, flush, full, empty, count.

Test Plan:
- Reset, then read ID -> ack exactly 1 cycle after stb; data 16'hF1F0; STATUS reads 16'h000A (both empty).
- Write 0x1111..0x1110+16 to TX_DATA with tx_tready=0 -> TX_LEVEL=16, tx_full=1.
  - 17th write is acked and dropped; STATUS bit4=1.
  - Then tx_tready=1 drains 0x1111 first, in order.
- Fabric pushes 0xA5A5, 0x5A5A; host reads RX_DATA twice -> 0xA5A5 then 0x5A5A.
  - Third read returns 0, rx_underflow=1; write STATUS 16'h0020 -> bit5 cleared.
- Write TX_DATA with sel=2'b01 -> no push, TX_LEVEL stays 0, bad_sel=1.
  - Write CTRL sel=2'b10 data 0x0004 -> rx_irq_en unchanged (0).
- Fill RX with 3 words, then write CTRL 0x0002 in the same cycle as an rx_tvalid push -> RX_LEVEL=0 and rx_empty=1 next cycle.
- Undecoded read at adr 0x010 -> acked, data 0; with WB_FIFO_SLAVE_IRQ_EN, rx_irq_en=1 and one RX word -> irq=1, clears after pop.
